// File: rtl/fp_mul_seq_pkg.sv
// Shared floating-point helpers for the sequential multiplier (package fp_pkg).
// Holds the controller state type, bias / canonical-NaN builders and
// operand classification helpers used by fp_mul_seq.
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } fp_mul_state_t;

  // Exponent bias for an exponent field of exp_w bits.
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  // Returned in a wide container; callers truncate to their format width.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

  // NaN: exponent all ones with a non-zero fraction.
  function automatic logic is_nan(input logic expOnes, input logic fracNz);
    return expOnes && fracNz;
  endfunction

  // Infinity: exponent all ones with a zero fraction.
  function automatic logic is_inf(input logic expOnes, input logic fracNz);
    return expOnes && !fracNz;
  endfunction

  // Zero: exponent zero; subnormals are deliberately folded into zero.
  function automatic logic is_zero(input logic expZero);
    return expZero;
  endfunction

endpackage

// File: rtl/fp_mul_seq_if.sv
// Request/response bundle of the sequential floating-point multiplier.
// The master side (operand register file / bench) drives start and operands;
// the slave side (fp_mul_seq) returns the result, handshake and status flags.
interface fp_mul_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int FP_W = 1 + EXP_W + MAN_W;

  logic            mul_start;
  logic [FP_W-1:0] op1;
  logic [FP_W-1:0] op2;
  logic [FP_W-1:0] mul_result;
  logic            mul_done;
  logic            mul_busy;
  logic            mul_overflow;
  logic            mul_underflow;
  logic            mul_invalid;

  modport master (
    output mul_start, op1, op2,
    input  mul_result, mul_done, mul_busy,
    input  mul_overflow, mul_underflow, mul_invalid
  );

  modport slave (
    input  mul_start, op1, op2,
    output mul_result, mul_done, mul_busy,
    output mul_overflow, mul_underflow, mul_invalid
  );

endinterface

// File: rtl/fp_mul_seq_mant.sv
// mant_seq_mul: iterative shift-add significand multiplier.
// load_i captures both significands and clears the accumulator; each step_i
// cycle consumes one multiplier bit, LSB first. done_o marks the final step,
// after which prod_o holds the full 2*SW-bit product.
module mant_seq_mul #(
  parameter int SW = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [SW-1:0]   a_i,
  input  logic [SW-1:0]   b_i,
  input  logic            step_i,
  output logic            done_o,
  output logic [2*SW-1:0] prod_o
);
  localparam int PW = 2 * SW;
  localparam int CW = (SW > 1) ? $clog2(SW) : 1;
  localparam logic [CW-1:0] LAST = CW'(SW - 1);

  logic [SW-1:0] mcand_q;
  logic [SW-1:0] mplier_q;
  logic [PW-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic [SW:0]   partial;

  // Add the multiplicand into the upper half when the current multiplier bit is set.
  always_comb begin
    partial = {1'b0, acc_q[PW-1:SW]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  end

  // Load operands, or shift the accumulator right one place per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= {partial, acc_q[SW-1:1]};
      mplier_q <= mplier_q >> 1;
      cnt_q    <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign done_o = step_i && (cnt_q == LAST);
  assign prod_o = acc_q;

endmodule

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: multi-cycle IEEE-754-style multiplier with start/done handshake.
// Sequence: IDLE -> MUL (MAN_W+1 cycles) -> NORM -> ROUND -> DONE -> IDLE,
// giving a fixed latency for every operand, specials included.
// Optional build macro FP_MUL_RNE_EN: round-to-nearest-even instead of truncation.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         rst,
  fp_mul_seq_if.slave  bus
);
  localparam int FP_W = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 1;
  localparam int PW   = 2 * SW;
  localparam int XW   = EXP_W + 2;
  localparam logic [XW-1:0]   BIAS    = XW'(fp_bias(EXP_W));
  localparam logic [XW-1:0]   EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic [FP_W-1:0] QNAN    = FP_W'(fp_qnan(EXP_W, MAN_W));
`ifdef FP_MUL_RNE_EN
  localparam bit RNE_EN = 1'b1;
`else
  localparam bit RNE_EN = 1'b0;
`endif

  fp_mul_state_t   state_q, state_d;
  logic [FP_W-1:0] opA_q, opB_q;
  logic [PW-2:0]   norm_q, norm_d;
  logic [XW-1:0]   exp_q, expNorm_d;
  logic [FP_W-1:0] result_q, result_d;
  logic            ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;

  logic            accept;
  logic            mulDone;
  logic [PW-1:0]   prod;

  logic            signR;
  logic [EXP_W-1:0] expA, expB;
  logic            nanA, nanB, infA, infB, zeroA, zeroB;

  logic [SW-1:0]   kept;
  logic            guardBit, roundBit, stickyBit, roundUp;
  logic [SW:0]     rounded;
  logic [MAN_W-1:0] fracRnd;
  logic [XW-1:0]   expRnd;

  assign accept = (state_q == S_IDLE) && bus.mul_start;

  mant_seq_mul #(.SW(SW)) u_mant (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .a_i    ({1'b1, bus.op1[MAN_W-1:0]}),
    .b_i    ({1'b1, bus.op2[MAN_W-1:0]}),
    .step_i (state_q == S_MUL),
    .done_o (mulDone),
    .prod_o (prod)
  );

  // Field extraction and special-operand classification of the captured operands.
  always_comb begin
    signR = opA_q[FP_W-1] ^ opB_q[FP_W-1];
    expA  = opA_q[FP_W-2:MAN_W];
    expB  = opB_q[FP_W-2:MAN_W];
    nanA  = is_nan(&expA, |opA_q[MAN_W-1:0]);
    nanB  = is_nan(&expB, |opB_q[MAN_W-1:0]);
    infA  = is_inf(&expA, |opA_q[MAN_W-1:0]);
    infB  = is_inf(&expB, |opB_q[MAN_W-1:0]);
    zeroA = is_zero(~|expA);
    zeroB = is_zero(~|expB);
  end

  // Controller sequencing; a start is only honoured while idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.mul_start) state_d = S_MUL;
      S_MUL:   if (mulDone) state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Put the leading one at the top of norm; the bit shifted out stays in the sticky region.
  always_comb begin
    if (prod[PW-1]) begin
      norm_d    = {prod[PW-1:2], prod[1] | prod[0]};
      expNorm_d = {2'b00, expA} + {2'b00, expB} - BIAS + XW'(1);
    end else begin
      norm_d    = prod[PW-2:0];
      expNorm_d = {2'b00, expA} + {2'b00, expB} - BIAS;
    end
  end

  // Round the kept significand and renormalise on a carry out of the top.
  always_comb begin
    kept      = norm_q[PW-2:SW-1];
    guardBit  = norm_q[SW-2];
    roundBit  = norm_q[SW-3];
    stickyBit = |norm_q[SW-4:0];
    roundUp   = RNE_EN && guardBit && (roundBit || stickyBit || kept[0]);
    rounded   = {1'b0, kept} + (SW+1)'(roundUp);
    if (rounded[SW]) begin
      fracRnd = rounded[SW-1:1];
      expRnd  = exp_q + XW'(1);
    end else begin
      fracRnd = rounded[MAN_W-1:0];
      expRnd  = exp_q;
    end
  end

  // Final result selection: specials first, then overflow/underflow, then the normal value.
  always_comb begin
    result_d = {signR, expRnd[EXP_W-1:0], fracRnd};
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    inv_d    = 1'b0;
    if (nanA || nanB || (infA && zeroB) || (zeroA && infB)) begin
      result_d = QNAN;
      inv_d    = 1'b1;
    end else if (infA || infB) begin
      result_d = {signR, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zeroA || zeroB) begin
      result_d = {signR, {(FP_W-1){1'b0}}};
    end else if (!expRnd[XW-1] && (expRnd >= EXP_MAX)) begin
      result_d = {signR, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d    = 1'b1;
    end else if (expRnd[XW-1] || (expRnd == '0)) begin
      result_d = {signR, {(FP_W-1){1'b0}}};
      unf_d    = 1'b1;
    end
  end

  // State, operand capture, pipeline registers and the held result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opA_q    <= '0;
      opB_q    <= '0;
      norm_q   <= '0;
      exp_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opA_q <= bus.op1;
        opB_q <= bus.op2;
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
        inv_q <= 1'b0;
      end
      if (state_q == S_NORM) begin
        norm_q <= norm_d;
        exp_q  <= expNorm_d;
      end
      if (state_q == S_ROUND) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
        inv_q    <= inv_d;
      end
    end
  end

  assign bus.mul_result    = result_q;
  assign bus.mul_done      = (state_q == S_DONE);
  assign bus.mul_busy      = (state_q == S_MUL) || (state_q == S_NORM) || (state_q == S_ROUND);
  assign bus.mul_overflow  = ovf_q;
  assign bus.mul_underflow = unf_q;
  assign bus.mul_invalid   = inv_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq (default single-precision build).
// A scoreboard predicts every output on every cycle from an integer-arithmetic
// reference multiply and the start/reset history; directed cases pin the
// reference with hand-computed values and cover the handshake corner cases.
module tb_fp_mul_seq;
  localparam int LAT = 27;
`ifdef FP_MUL_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic clk;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  fp_mul_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_mul_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index; cycle n is the interval following the n-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference single-precision multiply using plain integer arithmetic.
  function automatic void refMul(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic [2:0] flags);
    int ea, eb, e, sh;
    longint unsigned sa, sb, p, kept, rem, half;
    logic s;
    bit na, nb, ia, ib, za, zb;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    za = (ea == 0);
    zb = (eb == 0);
    flags = 3'b000;
    if (na || nb || (ia && zb) || (za && ib)) begin
      r = 32'h7FC00000;
      flags = 3'b001;
      return;
    end
    if (ia || ib) begin
      r = {s, 8'hFF, 23'h0};
      return;
    end
    if (za || zb) begin
      r = {s, 31'h0};
      return;
    end
    sa = 64'd8388608 + longint'(a[22:0]);
    sb = 64'd8388608 + longint'(b[22:0]);
    p  = sa * sb;
    e  = ea + eb - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end
    kept = p >> sh;
    rem  = p - (kept << sh);
    half = 64'd1 << (sh - 1);
    if (RNE && ((rem > half) || ((rem == half) && ((kept % 2) == 1)))) kept = kept + 1;
    if (kept == (64'd1 << 24)) begin
      kept = kept >> 1;
      e    = e + 1;
    end
    if (e >= 255) begin
      r = {s, 8'hFF, 23'h0};
      flags = 3'b100;
    end else if (e <= 0) begin
      r = {s, 31'h0};
      flags = 3'b010;
    end else begin
      r = {s, 8'(e), 23'(kept)};
    end
  endfunction

  // Scoreboard state: what the outputs must show, derived from start/reset history.
  bit          sbValid = 1'b0;
  bit          pending = 1'b0;
  int          accCyc = 0;
  logic [31:0] pendRes, heldRes;
  logic [2:0]  pendFlags, heldFlags;

  // Compare every output each cycle, then fold this cycle's inputs into the model.
  always @(negedge clk) begin
    bit expDone, expBusy, wasIdle;
    if (sbValid) begin
      expDone = pending && (cyc == accCyc + LAT);
      expBusy = pending && (cyc > accCyc) && (cyc < accCyc + LAT);
      if (expDone) begin
        heldRes   = pendRes;
        heldFlags = pendFlags;
      end
      checkOutput("mul_done", 32'(bus.mul_done), 32'(expDone));
      checkOutput("mul_busy", 32'(bus.mul_busy), 32'(expBusy));
      checkOutput("mul_result", bus.mul_result, heldRes);
      checkOutput("flags{ovf,unf,inv}", 32'({bus.mul_overflow, bus.mul_underflow, bus.mul_invalid}),
                  32'(heldFlags));
    end
    wasIdle = !pending;
    if (pending && (cyc == accCyc + LAT)) pending = 1'b0;
    if (rst) begin
      pending   = 1'b0;
      heldRes   = '0;
      heldFlags = '0;
      sbValid   = 1'b1;
    end else if (sbValid && wasIdle && bus.mul_start) begin
      pending   = 1'b1;
      accCyc    = cyc;
      heldFlags = '0;
      refMul(bus.op1, bus.op2, pendRes, pendFlags);
    end
  end

  // Issue one operation and wait (bounded) for its done pulse.
  // junkAt > 0 pulses mul_start with unrelated operands that many cycles after the accept.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int junkAt,
                               output logic [31:0] res, output logic [2:0] flags, output int lat);
    int startCyc;
    @(posedge clk); #1;
    bus.op1 = a;
    bus.op2 = b;
    bus.mul_start = 1'b1;
    startCyc = cyc;
    lat = -1;
    res = '0;
    flags = '0;
    @(posedge clk); #1;
    for (int i = 1; i <= 40; i++) begin
      bus.mul_start = (i == junkAt);
      bus.op1 = $urandom;
      bus.op2 = $urandom;
      @(negedge clk);
      if (bus.mul_done) begin
        res   = bus.mul_result;
        flags = {bus.mul_overflow, bus.mul_underflow, bus.mul_invalid};
        lat   = cyc - startCyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) checkOutput("done timeout", 32'(lat), 32'(LAT));
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.mul_start = 1'b0;
    end
  endtask

  function automatic logic [31:0] randOp();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 9))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 8));
      3:       e = 8'($urandom_range(240, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    case ($urandom_range(0, 4))
      0:       f = 23'h0;
      1:       f = 23'h7FFFFF;
      default: f = 23'($urandom);
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Directed cases, mid-operation reset, then randomised back-to-back traffic.
  initial begin
    logic [31:0] r;
    logic [2:0]  fl;
    int          lat, s, doneSeen;

    rst = 1'b1;
    bus.mul_start = 1'b0;
    bus.op1 = '0;
    bus.op2 = '0;

    refMul(32'h3FA00000, 32'h3FC00000, r, fl);
    checkOutput("model 1.25x1.5", r, 32'h3FF00000);
    refMul(32'h40000000, 32'h40400000, r, fl);
    checkOutput("model 2x3", r, 32'h40C00000);
    refMul(32'h3FC00001, 32'h3FC00001, r, fl);
    checkOutput("model rounding", r, RNE ? 32'h40100002 : 32'h40100001);
    refMul(32'h7F000000, 32'h7F000000, r, fl);
    checkOutput("model overflow", {fl, r[28:0]}, {3'b100, 29'h1F800000});
    refMul(32'h7F800000, 32'h00000000, r, fl);
    checkOutput("model inf x 0", {fl, r[28:0]}, {3'b001, 29'h1FC00000});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(32'h3FA00000, 32'h3FC00000, 0, r, fl, lat);
    checkOutput("1.25x1.5 result", r, 32'h3FF00000);
    checkOutput("1.25x1.5 latency", 32'(lat), 32'(LAT));
    checkOutput("1.25x1.5 flags", 32'(fl), 32'h0);
    applyStimulus(32'h40000000, 32'h40400000, 0, r, fl, lat);
    checkOutput("2x3 result", r, 32'h40C00000);
    applyStimulus(32'h3FC00001, 32'h3FC00001, 0, r, fl, lat);
    checkOutput("rounding result", r, RNE ? 32'h40100002 : 32'h40100001);
    applyStimulus(32'h7F000000, 32'h7F000000, 0, r, fl, lat);
    checkOutput("overflow result", r, 32'h7F800000);
    checkOutput("overflow flags", 32'(fl), 32'h4);
    applyStimulus(32'h00800000, 32'h00800000, 0, r, fl, lat);
    checkOutput("underflow result", r, 32'h00000000);
    checkOutput("underflow flags", 32'(fl), 32'h2);
    applyStimulus(32'h7F800000, 32'h00000000, 0, r, fl, lat);
    checkOutput("inf x 0 result", r, 32'h7FC00000);
    checkOutput("inf x 0 flags", 32'(fl), 32'h1);
    applyStimulus(32'hFF800000, 32'h40000000, 0, r, fl, lat);
    checkOutput("-inf x 2 result", r, 32'hFF800000);
    checkOutput("-inf x 2 flags", 32'(fl), 32'h0);
    applyStimulus(32'h3FA00000, 32'h3FC00000, 5, r, fl, lat);
    checkOutput("ignored start result", r, 32'h3FF00000);
    checkOutput("ignored start latency", 32'(lat), 32'(LAT));
    applyStimulus(32'h40000000, 32'h40400000, LAT, r, fl, lat);
    checkOutput("start in done cycle result", r, 32'h40C00000);
    idleCycles(2);

    // Abort an operation with a reset ten cycles after the accept.
    @(posedge clk); #1;
    bus.op1 = 32'h3FA00000;
    bus.op2 = 32'h3FC00000;
    bus.mul_start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    bus.mul_start = 1'b0;
    for (int i = 0; i < 20 && cyc < s + 10; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset busy", 32'(bus.mul_busy), 32'h0);
    checkOutput("post-reset result", bus.mul_result, 32'h0);
    doneSeen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.mul_done) doneSeen++;
    end
    checkOutput("aborted op done count", 32'(doneSeen), 32'h0);

    for (int k = 0; k < 150; k++) begin
      int junk;
      junk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT)) : 0;
      applyStimulus(randOp(), randOp(), junk, r, fl, lat);
      if ($urandom_range(0, 2) == 0) idleCycles(int'($urandom_range(1, 3)));
    end
    idleCycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
